reflet_exti_n: RTL

- Parametrised interrupt controller: multiplexes NUM_SRC peripheral interrupt sources onto the 4 CPU interrupt lines.
- Per-source controls: enable, trigger mode (sticky rising-edge or level), and line select.
- Per-line cause registers hold the lowest-numbered pending source, so the ISR does not have to scan status.
- Sits on the 8-bit system bus beside the other peripherals; its outputs drive cpu_int directly.

---
 rtl/reflet_exti_n.sv | 114 +++++++++++
 1 files changed

// File: rtl/reflet_exti_n.sv
// Interrupt controller: routes NUM_SRC peripheral interrupt sources onto 4 CPU lines,
// with per-source enable, edge/level mode and line select, plus per-line cause registers.
module reflet_exti_n #(
    parameter int unsigned base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr = 16'hFF04,
    parameter int unsigned NUM_SRC = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    output logic [3:0]                cpu_int,
    input  logic [NUM_SRC-1:0]        src_int
);

    localparam int unsigned B         = (NUM_SRC + 7) / 8;
    localparam int unsigned OffEn     = 0;
    localparam int unsigned OffMode   = B;
    localparam int unsigned OffLine   = 2 * B;
    localparam int unsigned OffStatus = 4 * B;
    localparam int unsigned OffCause  = 5 * B;
    localparam int unsigned OffEnd    = 5 * B + 4;

    logic [NUM_SRC-1:0]   en_q, en_d;
    logic [NUM_SRC-1:0]   mode_q, mode_d;
    logic [2*NUM_SRC-1:0] line_q, line_d;
    logic [NUM_SRC-1:0]   status_q, status_d;
    logic [NUM_SRC-1:0]   src_prev_q;

    logic [base_addr_size-1:0] diff;
    logic [31:0]               off;
    logic                      sel;
    logic                      wr;

    logic [3:0] cause_valid;
    logic [5:0] cause_idx [4];

    // Addresses below base_addr wrap to a large offset and fall out of range.
    assign diff = addr - base_addr;
    assign off  = 32'(diff);
    assign sel  = enable && (off < OffEnd);
    assign wr   = sel && write_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q       <= '0;
            mode_q     <= '0;
            line_q     <= '0;
            status_q   <= '0;
            src_prev_q <= src_int;
        end else begin
            en_q       <= en_d;
            mode_q     <= mode_d;
            line_q     <= line_d;
            status_q   <= status_d;
            src_prev_q <= src_int;
        end
    end

    always_comb begin
        en_d     = en_q;
        mode_d   = mode_q;
        line_d   = line_q;
        status_d = status_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (wr && off == OffEn + i / 8) en_d[i] = data_in[i % 8];
            if (wr && off == OffMode + i / 8) mode_d[i] = data_in[i % 8];
            if (wr && off == OffLine + i / 4) line_d[2*i +: 2] = data_in[2*(i % 4) +: 2];
            if (mode_q[i]) begin
                status_d[i] = src_int[i];
            end else begin
                // A new edge wins over a same-cycle write-1-clear.
                status_d[i] = (src_int[i] & ~src_prev_q[i]) |
                              (status_q[i] & ~(wr && off == OffStatus + i / 8 &&
                                               data_in[i % 8]));
            end
        end
    end

    // Scan from the top so the lowest-numbered active source is the last one written.
    always_comb begin
        cause_valid = '0;
        for (int k = 0; k < 4; k++) begin
            cause_idx[k] = '0;
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (status_q[i] && en_q[i] && line_q[2*i +: 2] == 2'(k)) begin
                    cause_valid[k] = 1'b1;
                    cause_idx[k]   = 6'(i);
                end
            end
        end
    end

    assign cpu_int = cause_valid;

    always_comb begin
        data_out = '0;
        if (sel) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (off == OffEn + i / 8) data_out[i % 8] = en_q[i];
                if (off == OffMode + i / 8) data_out[i % 8] = mode_q[i];
                if (off == OffLine + i / 4) data_out[2*(i % 4) +: 2] = line_q[2*i +: 2];
                if (off == OffStatus + i / 8) data_out[i % 8] = status_q[i];
            end
            for (int unsigned k = 0; k < 4; k++) begin
                if (off == OffCause + k) data_out = {cause_valid[k], 1'b0, cause_idx[k]};
            end
        end
    end

endmodule
